// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, selects start / redirect / hold / +stride,
// and gates fetch on instruction-buffer back-pressure and the WFI/exception drain.
module ifu_fetch_ctrl #(
    parameter int PC_WIDTH      = 32,
    parameter int EXCEPTION_NUM = 2,
    parameter int FETCH_STRIDE  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_pulse,
    input  logic [PC_WIDTH-1:0]      start_pc,
    input  logic [EXCEPTION_NUM-1:0] core_configuration,
    input  logic                     idu_ifu_instBuffer_full,
    input  logic                     idu_ifu_detect_exceptions_wfi,
    input  logic                     iex_ifu_report_exceptions_wfi,
    input  logic                     iex_ifu_bru_flush,
    input  logic [PC_WIDTH-1:0]      iex_ifu_bru_redir_pc,
    output logic                     ifu_fetch_vld,
    output logic [PC_WIDTH-1:0]      ifu_fetch_pc_1,
    output logic [PC_WIDTH-1:0]      ifu_fetch_pc_2,
    output logic                     ifu_fetch_pc_unalign_1,
    output logic                     ifu_fetch_pc_unalign_2,
    output logic                     ifu_csr_start_pulse,
    output logic [EXCEPTION_NUM-1:0] ifu_csr_core_configuration,
    output logic [1:0]               ifu_fetch_state
);

    // Handshake: a fetch PC pair is consumed by stage 1 in every cycle where
    // ifu_fetch_vld is high; there is no ready, back-pressure arrives only
    // through idu_ifu_instBuffer_full, which drops vld in the same cycle.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [PC_WIDTH-1:0] SLOT_OFFSET = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] STRIDE      = PC_WIDTH'(FETCH_STRIDE);

    state_t                     state_q, state_d;
    logic [PC_WIDTH-1:0]        pc_q, pc_d;
    logic [PC_WIDTH-1:0]        pc2_q;
    logic                       csr_start_q;
    logic [EXCEPTION_NUM-1:0]   cfg_q;
    logic                       start_block_q;
    logic                       start_accept;
    logic                       vld;

    assign vld = (state_q == ST_RUN) && !idu_ifu_instBuffer_full;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        start_accept = 1'b0;
        if (iex_ifu_bru_flush && (state_q == ST_RUN || state_q == ST_DRAIN)) begin
            // Redirect beats a same-cycle WFI detect or report: the WFI was younger.
            state_d = ST_RUN;
            pc_d    = iex_ifu_bru_redir_pc;
        end else if (start_pulse && !start_block_q &&
                     (state_q == ST_IDLE || state_q == ST_HALT)) begin
            state_d      = ST_RUN;
            pc_d         = start_pc;
            start_accept = 1'b1;
        end else if (idu_ifu_detect_exceptions_wfi && state_q == ST_RUN) begin
            state_d = ST_DRAIN;
        end else if (iex_ifu_report_exceptions_wfi && state_q == ST_DRAIN) begin
            state_d = ST_HALT;
        end else if (vld) begin
            pc_d = pc_q + STRIDE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            pc2_q         <= '0;
            csr_start_q   <= 1'b0;
            cfg_q         <= '0;
            start_block_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            // Slot-1 PC is registered so that it reads zero out of reset.
            pc2_q       <= pc_d + SLOT_OFFSET;
            csr_start_q <= start_accept;
            if (start_accept) begin
                cfg_q <= core_configuration;
            end
            // A held start pulse must only start the core once.
            if (start_accept) begin
                start_block_q <= 1'b1;
            end else if (!start_pulse) begin
                start_block_q <= 1'b0;
            end
        end
    end

    assign ifu_fetch_vld              = vld;
    assign ifu_fetch_pc_1             = pc_q;
    assign ifu_fetch_pc_2             = pc2_q;
    assign ifu_fetch_pc_unalign_1     = |pc_q[1:0];
    assign ifu_fetch_pc_unalign_2     = |pc2_q[1:0];
    assign ifu_csr_start_pulse        = csr_start_q;
    assign ifu_csr_core_configuration = cfg_q;
    assign ifu_fetch_state            = state_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: start, stall, redirect, drain/halt, wrap and async reset.
module tb_ifu_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_pulse;
    logic [31:0] start_pc;
    logic [1:0]  core_configuration;
    logic        full;
    logic        detect;
    logic        report;
    logic        flush;
    logic [31:0] redir_pc;
    logic        vld;
    logic [31:0] pc_1;
    logic [31:0] pc_2;
    logic        ua_1;
    logic        ua_2;
    logic        csr_start;
    logic [1:0]  csr_cfg;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    ifu_fetch_ctrl dut (
        .clk                           (clk),
        .rst_n                         (rst_n),
        .start_pulse                   (start_pulse),
        .start_pc                      (start_pc),
        .core_configuration            (core_configuration),
        .idu_ifu_instBuffer_full       (full),
        .idu_ifu_detect_exceptions_wfi (detect),
        .iex_ifu_report_exceptions_wfi (report),
        .iex_ifu_bru_flush             (flush),
        .iex_ifu_bru_redir_pc          (redir_pc),
        .ifu_fetch_vld                 (vld),
        .ifu_fetch_pc_1                (pc_1),
        .ifu_fetch_pc_2                (pc_2),
        .ifu_fetch_pc_unalign_1        (ua_1),
        .ifu_fetch_pc_unalign_2        (ua_2),
        .ifu_csr_start_pulse           (csr_start),
        .ifu_csr_core_configuration    (csr_cfg),
        .ifu_fetch_state               (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle before inputs change or outputs are checked.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vld"},   {31'd0, vld},       32'd0);
        check({tag, "_pc1"},   pc_1,               32'd0);
        check({tag, "_pc2"},   pc_2,               32'd0);
        check({tag, "_ua"},    {30'd0, ua_1, ua_2}, 32'd0);
        check({tag, "_csr"},   {31'd0, csr_start}, 32'd0);
        check({tag, "_cfg"},   {30'd0, csr_cfg},   32'd0);
        check({tag, "_state"}, {30'd0, state},     32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start_pulse = 1'b0; start_pc = '0; core_configuration = '0;
        full = 1'b0; detect = 1'b0; report = 1'b0; flush = 1'b0; redir_pc = '0;
        #23;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check("idle_state", {30'd0, state}, 32'd0);
        check("idle_vld", {31'd0, vld}, 32'd0);

        // T1: start at 0x10 with cfg 01
        start_pulse = 1'b1; start_pc = 32'h10; core_configuration = 2'b01;
        tick();
        start_pulse = 1'b0; start_pc = 32'h0; core_configuration = 2'b10;
        check("t1_pc1", pc_1, 32'h10);
        check("t1_pc2", pc_2, 32'h14);
        check("t1_vld", {31'd0, vld}, 32'd1);
        check("t1_csr", {31'd0, csr_start}, 32'd1);
        check("t1_cfg", {30'd0, csr_cfg}, 32'd1);
        check("t1_state", {30'd0, state}, 32'd1);
        tick();
        check("t1_pc1_next", pc_1, 32'h18);
        check("t1_csr_drop", {31'd0, csr_start}, 32'd0);
        check("t1_cfg_hold", {30'd0, csr_cfg}, 32'd1);
        tick();
        check("t2_pc1_pre", pc_1, 32'h20);

        // T2: three cycles of back-pressure at 0x20
        full = 1'b1;
        #1;
        check("t2_vld_gate", {31'd0, vld}, 32'd0);
        tick(); tick(); tick();
        check("t2_pc_held", pc_1, 32'h20);
        check("t2_vld_low", {31'd0, vld}, 32'd0);
        full = 1'b0;
        #1;
        check("t2_vld_back", {31'd0, vld}, 32'd1);
        check("t2_pc_same", pc_1, 32'h20);
        tick();
        check("t2_pc_next", pc_1, 32'h28);

        // T3: flush and start together in RUN -> redirect only
        flush = 1'b1; redir_pc = 32'h41; start_pulse = 1'b1; start_pc = 32'h300;
        tick();
        flush = 1'b0; start_pulse = 1'b0;
        check("t3_pc1", pc_1, 32'h41);
        check("t3_pc2", pc_2, 32'h45);
        check("t3_ua1", {31'd0, ua_1}, 32'd1);
        check("t3_ua2", {31'd0, ua_2}, 32'd1);
        check("t3_no_csr", {31'd0, csr_start}, 32'd0);
        tick();
        check("t3_pc1_next", pc_1, 32'h49);
        check("t3_ua_persist", {31'd0, ua_1}, 32'd1);

        // T4: detect -> DRAIN, report -> HALT, held start -> one restart at 0x100
        detect = 1'b1;
        #1;
        check("t4_same_cycle_vld", {31'd0, vld}, 32'd1);
        tick();
        detect = 1'b0;
        check("t4_drain", {30'd0, state}, 32'd2);
        check("t4_drain_vld", {31'd0, vld}, 32'd0);
        check("t4_drain_pc", pc_1, 32'h49);
        report = 1'b1;
        tick();
        report = 1'b0;
        check("t4_halt", {30'd0, state}, 32'd3);
        check("t4_halt_vld", {31'd0, vld}, 32'd0);
        flush = 1'b1; redir_pc = 32'h500;
        tick();
        flush = 1'b0;
        check("t4_halt_flush_ign", {30'd0, state}, 32'd3);
        start_pulse = 1'b1; start_pc = 32'h100;
        tick();
        check("t4_restart_pc", pc_1, 32'h100);
        check("t4_restart_state", {30'd0, state}, 32'd1);
        check("t4_restart_csr", {31'd0, csr_start}, 32'd1);
        tick();
        start_pulse = 1'b0;
        check("t4_held_pc", pc_1, 32'h108);
        check("t4_held_csr", {31'd0, csr_start}, 32'd0);

        // T5: flush and report together in DRAIN -> flush wins
        detect = 1'b1;
        tick();
        detect = 1'b0;
        check("t5_drain", {30'd0, state}, 32'd2);
        flush = 1'b1; redir_pc = 32'h80; report = 1'b1;
        tick();
        flush = 1'b0; report = 1'b0;
        check("t5_state", {30'd0, state}, 32'd1);
        check("t5_pc1", pc_1, 32'h80);
        check("t5_vld", {31'd0, vld}, 32'd1);

        // Flush with detect in RUN lands in RUN; then the wrap case
        flush = 1'b1; detect = 1'b1; redir_pc = 32'hFFFF_FFF8;
        tick();
        flush = 1'b0; detect = 1'b0;
        check("t6_state", {30'd0, state}, 32'd1);
        check("t6_pc1", pc_1, 32'hFFFF_FFF8);
        check("t6_pc2", pc_2, 32'hFFFF_FFFC);
        tick();
        check("t6_wrap_pc1", pc_1, 32'h0);
        check("t6_wrap_pc2", pc_2, 32'h4);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_async_rst");
        tick();
        check_all_zero("t6_rst_hold");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
